// File: rtl/sram_axi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_master_bridge
// Description : Converts an SRAM-style core request interface into single-beat
//               AXI3 read/write transactions, one transaction outstanding.
//               Optional macro SRAM_AXI_BRIDGE_RESP_ERR_EN enables the err
//               pulse on non-OKAY RRESP/BRESP.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_axi_master_bridge #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int MASTER_ID  = 0
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   // core side
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [STRB_WIDTH-1:0] wem,
   output logic                  addr_ok,
   output logic                  data_ok,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  err,
   // AXI write address / data / response
   output logic [ADDR_WIDTH-1:0] AWADDR,
   output logic [3:0]            AWLEN,
   output logic [2:0]            AWSIZE,
   output logic [1:0]            AWBURST,
   output logic [ID_WIDTH-1:0]   AWID,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [DATA_WIDTH-1:0] WDATA,
   output logic [STRB_WIDTH-1:0] WSTRB,
   output logic                  WLAST,
   output logic [ID_WIDTH-1:0]   WID,
   output logic                  WVALID,
   input  logic                  WREADY,
   input  logic [ID_WIDTH-1:0]   BID,
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY,
   // AXI read address / data
   output logic [ADDR_WIDTH-1:0] ARADDR,
   output logic [3:0]            ARLEN,
   output logic [2:0]            ARSIZE,
   output logic [1:0]            ARBURST,
   output logic [ID_WIDTH-1:0]   ARID,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [DATA_WIDTH-1:0] RDATA,
   input  logic [1:0]            RRESP,
   input  logic                  RLAST,
   input  logic [ID_WIDTH-1:0]   RID,
   input  logic                  RVALID,
   output logic                  RREADY
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RADDR = 3'd1,
      S_RDATA = 3'd2,
      S_WREQ  = 3'd3,
      S_WRESP = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_WIDTH-1:0] r_wem;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic                  r_data_ok;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  w_accept;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_wr_both;
   logic                  w_rd_done;
   logic                  w_wr_resp;

   // Fixed single-beat, 32-bit, INCR burst attributes and constant IDs
   assign AWLEN   = 4'd0;
   assign ARLEN   = 4'd0;
   assign AWSIZE  = 3'b010;
   assign ARSIZE  = 3'b010;
   assign AWBURST = 2'b01;
   assign ARBURST = 2'b01;
   assign AWID    = ID_WIDTH'(MASTER_ID);
   assign WID     = ID_WIDTH'(MASTER_ID);
   assign ARID    = ID_WIDTH'(MASTER_ID);

   // Payload comes straight from the capture registers so it stays stable
   // for the whole time the matching VALID is high.
   assign AWADDR  = r_addr;
   assign ARADDR  = r_addr;
   assign WDATA   = r_wdata;
   assign WSTRB   = r_wem;

   assign addr_ok  = (r_state == S_IDLE);
   assign w_accept = req && addr_ok;

   // Handshake terms; a channel already accepted no longer participates
   assign w_aw_hs   = (r_state == S_WREQ) && !r_aw_done && AWREADY;
   assign w_w_hs    = (r_state == S_WREQ) && !r_w_done && WREADY;
   assign w_wr_both = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
   assign w_rd_done = (r_state == S_RDATA) && RVALID;
   assign w_wr_resp = (r_state == S_WRESP) && BVALID;

   assign data_ok = r_data_ok;
   assign err     = r_err;
   assign rdata   = r_rdata;

   // IDs, RLAST and (without the error option) response codes are not used
`ifdef SRAM_AXI_BRIDGE_RESP_ERR_EN
   logic w_unused_ok;
   assign w_unused_ok = ^{BID, RID, RLAST, r_we};
`else
   logic w_unused_ok;
   assign w_unused_ok = ^{BID, RID, RLAST, r_we, RRESP, BRESP};
`endif

   // State register
   always_ff @(posedge ACLK) begin
      if (!ARESETn) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode and channel VALID/READY generation
   always_comb begin
      w_state_nxt = r_state;
      AWVALID     = 1'b0;
      WVALID      = 1'b0;
      WLAST       = 1'b0;
      BREADY      = 1'b0;
      ARVALID     = 1'b0;
      RREADY      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req) w_state_nxt = we ? S_WREQ : S_RADDR;
         end
         S_RADDR: begin
            ARVALID = 1'b1;
            if (ARREADY) w_state_nxt = S_RDATA;
         end
         S_RDATA: begin
            RREADY = 1'b1;
            if (RVALID) w_state_nxt = S_IDLE;
         end
         S_WREQ: begin
            AWVALID = !r_aw_done;
            WVALID  = !r_w_done;
            WLAST   = !r_w_done;
            if (w_wr_both) w_state_nxt = S_WRESP;
         end
         S_WRESP: begin
            BREADY = 1'b1;
            if (BVALID) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Capture the core request at acceptance
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_wem   <= '0;
      end else if (w_accept) begin
         r_addr  <= addr;
         r_we    <= we;
         r_wdata <= wdata;
         r_wem   <= wem;
      end
   end

   // Track which write channels have completed; cleared outside WREQ
   always_ff @(posedge ACLK) begin
      if (!ARESETn || (r_state != S_WREQ) || w_wr_both) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_aw_done <= r_aw_done | w_aw_hs;
         r_w_done  <= r_w_done | w_w_hs;
      end
   end

   // Completion pulse, read data capture and optional error flag
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_data_ok <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_data_ok <= w_rd_done || w_wr_resp;
         if (w_rd_done) r_rdata <= RDATA;
`ifdef SRAM_AXI_BRIDGE_RESP_ERR_EN
         r_err <= (w_rd_done && (RRESP != 2'b00)) || (w_wr_resp && (BRESP != 2'b00));
`else
         r_err <= 1'b0;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_axi_master_bridge
// Description : Directed, table-driven self-checking bench for
//               sram_axi_master_bridge, plus back-to-back and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_axi_master_bridge;

`ifdef SRAM_AXI_BRIDGE_RESP_ERR_EN
   localparam bit c_ERR_EN = 1'b1;
`else
   localparam bit c_ERR_EN = 1'b0;
`endif

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  wem;
   logic        addr_ok, data_ok, err;
   logic [31:0] rdata;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [3:0]  AWLEN, ARLEN, AWID, WID, ARID, BID, RID, WSTRB;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

   int n_chk  = 0;
   int n_pass = 0;

   sram_axi_master_bridge dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req(req), .we(we), .addr(addr), .wdata(wdata), .wem(wem),
      .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WID(WID),
      .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARID(ARID), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID),
      .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wem;
      logic [31:0] srdata;
      logic [1:0]  resp;
      int          ar_dly;
      int          aw_dly;
      int          w_dly;
      int          exp_done;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // One transaction with per-channel READY delays; cycle 0 is the accept cycle
   task automatic run_txn(input vec_t v, input int idx);
      logic exp_arv, exp_rr, exp_awv, exp_wv, exp_br, exp_dok, exp_aok, exp_err;
      req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; wem = v.wem;
      ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
      RVALID = 1'b1; BVALID = 1'b1; RDATA = v.srdata; RRESP = v.resp; BRESP = v.resp;
      chk($sformatf("v%0d addr_ok_accept", idx), addr_ok, 1'b1);
      for (int c = 1; c <= v.exp_done + 1; c++) begin
         tick();
         // core keeps a different request up for one busy cycle; it must be ignored
         req     = (c == 1);
         we      = ~v.we;
         addr    = ~v.addr;
         wdata   = ~v.wdata;
         ARREADY = (c >= 1 + v.ar_dly);
         AWREADY = (c >= 1 + v.aw_dly);
         WREADY  = (c >= 1 + v.w_dly);
         exp_arv = !v.we && (c <= 1 + v.ar_dly);
         exp_rr  = !v.we && (c == 2 + v.ar_dly);
         exp_awv = v.we && (c <= 1 + v.aw_dly);
         exp_wv  = v.we && (c <= 1 + v.w_dly);
         exp_br  = v.we && (c == v.exp_done - 1);
         exp_dok = (c == v.exp_done);
         exp_aok = (c >= v.exp_done);
         exp_err = exp_dok && c_ERR_EN && (v.resp != 2'b00);
         chk($sformatf("v%0d c%0d ctl", idx, c),
             {ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY, data_ok, addr_ok, err},
             {exp_arv, exp_rr, exp_awv, exp_wv, exp_wv, exp_br, exp_dok, exp_aok, exp_err});
         if (c == 1)
            chk($sformatf("v%0d attrs", idx),
                {AWLEN, ARLEN, AWSIZE, ARSIZE, AWBURST, ARBURST, AWID, WID, ARID},
                {4'd0, 4'd0, 3'd2, 3'd2, 2'd1, 2'd1, 4'd0, 4'd0, 4'd0});
         if (ARVALID) chk($sformatf("v%0d c%0d ARADDR", idx, c), ARADDR, v.addr);
         if (AWVALID) chk($sformatf("v%0d c%0d AWADDR", idx, c), AWADDR, v.addr);
         if (WVALID)  chk($sformatf("v%0d c%0d WDATA/WSTRB", idx, c), {WDATA, WSTRB}, {v.wdata, v.wem});
         if (exp_dok) chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
      end
      req = 1'b0;
   endtask

   initial begin
      int pulses;
      // {we, addr, wdata, wem, slave rdata, resp, ar_dly, aw_dly, w_dly, done cycle, rdata}
      vecs[0] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 3, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 4'h3, 32'h5555_5555, 2'b00, 0, 3, 0, 6, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 32'h0000_0200, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00, 5, 0, 0, 8, 32'hCAFE_F00D};
      vecs[3] = '{1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 4'hF, 32'h7777_7777, 2'b10, 0, 0, 2, 5, 32'hCAFE_F00D};
      vecs[4] = '{1'b0, 32'h0000_0404, 32'h0,         4'h0, 32'h0BAD_F00D, 2'b01, 1, 0, 0, 4, 32'h0BAD_F00D};
      vecs[5] = '{1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 4'h8, 32'h1212_1212, 2'b00, 0, 2, 2, 5, 32'h0BAD_F00D};

      ARESETn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wem = '0;
      AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
      BID = 4'h5; BRESP = 2'b00; BVALID = 1'b1;
      RDATA = 32'hFFFF_FFFF; RRESP = 2'b00; RLAST = 1'b1; RID = 4'h7; RVALID = 1'b1;

      // Reset state
      tick();
      tick();
      chk("reset ctl", {addr_ok, ARVALID, RREADY, AWVALID, WVALID, BREADY, data_ok, err},
          8'b1000_0000);
      chk("reset rdata", rdata, 32'h0);
      ARESETn = 1'b1;
      tick();

      // Table-driven transactions
      for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

      // Back-to-back read then write with a zero-wait slave
      pulses = 0;
      ARREADY = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
      RVALID = 1'b1; BVALID = 1'b1; RDATA = 32'h1122_3344; RRESP = 2'b00; BRESP = 2'b00;
      for (int c = 0; c < 8; c++) begin
         req   = (c == 0) || (c == 3);
         we    = (c == 3);
         addr  = (c == 3) ? 32'h0000_0500 : 32'h0000_0480;
         wdata = 32'h600D_600D;
         wem   = 4'hF;
         if (data_ok) pulses++;
         chk($sformatf("b2b c%0d ctl", c), {data_ok, addr_ok, AWVALID, WVALID},
             {(c == 3) || (c == 6), (c == 0) || (c == 3) || (c >= 6), c == 4, c == 4});
         if (c == 3) chk("b2b rdata", rdata, 32'h1122_3344);
         if (c == 4) chk("b2b AWADDR", AWADDR, 32'h0000_0500);
         tick();
      end
      req = 1'b0;
      chk("b2b pulses", pulses, 2);

      // Reset while waiting in the read-data state
      RVALID = 1'b0; ARREADY = 1'b1;
      req = 1'b1; we = 1'b0; addr = 32'h0000_0700;
      tick();
      req = 1'b0;
      chk("rst-mid ARVALID", ARVALID, 1'b1);
      tick();
      chk("rst-mid RREADY", RREADY, 1'b1);
      ARESETn = 1'b0; RVALID = 1'b1; RDATA = 32'hFFFF_0000;
      tick();
      chk("rst-mid ctl", {ARVALID, RREADY, AWVALID, WVALID, BREADY, data_ok, err}, 7'b0);
      chk("rst-mid rdata", rdata, 32'h0);
      ARESETn = 1'b1;
      tick();
      chk("rst-mid release", {addr_ok, data_ok}, 2'b10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_axi_master_bridge.md
SRAM_AXI_MASTER_BRIDGE -- requirements
Module: sram_axi_master_bridge

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, data bus width; ADDR_WIDTH, 32, address width; ID_WIDTH, 4, AXI ID width; STRB_WIDTH, DATA_WIDTH/8, strobe width; MASTER_ID, 0, value driven on AWID/WID/ARID.
REQ-002 SHALL have ports: ACLK in 1 clock; ARESETn in 1 reset (synchronous, active-low); clock ACLK, reset ARESETn.
REQ-003 SHALL have core-side ports: req in 1 request; we in 1 write (1) / read (0); addr in ADDR_WIDTH byte address; wdata in DATA_WIDTH write data; wem in STRB_WIDTH byte enables; addr_ok out 1 request accepted; data_ok out 1 completion pulse; rdata out DATA_WIDTH read data; err out 1 error pulse.
REQ-004 SHALL have AXI write ports: AWADDR out ADDR_WIDTH; AWLEN out 4; AWSIZE out 3; AWBURST out 2; AWID out ID_WIDTH; AWVALID out 1; AWREADY in 1; WDATA out DATA_WIDTH; WSTRB out STRB_WIDTH; WLAST out 1; WID out ID_WIDTH; WVALID out 1; WREADY in 1; BID in ID_WIDTH; BRESP in 2; BVALID in 1; BREADY out 1.
REQ-005 SHALL have AXI read ports: ARADDR out ADDR_WIDTH; ARLEN out 4; ARSIZE out 3; ARBURST out 2; ARID out ID_WIDTH; ARVALID out 1; ARREADY in 1; RDATA in DATA_WIDTH; RRESP in 2; RLAST in 1; RID in ID_WIDTH; RVALID in 1; RREADY out 1.

Function
REQ-006 SHALL issue single-beat transfers only: AWLEN=ARLEN=0, AWSIZE=ARSIZE=3'b010, AWBURST=ARBURST=2'b01, WLAST=1 whenever WVALID=1; IDs constant MASTER_ID.
REQ-007 SHALL use FSM states IDLE, RADDR, RDATA, WREQ, WRESP; one transaction outstanding at a time.
REQ-008 SHALL drive addr_ok combinationally = (state==IDLE); request accepted in the cycle req&&addr_ok, capturing addr, we, wdata, wem into registers.
REQ-009 IDLE: accepted read -> RADDR with ARVALID=1 next cycle; accepted write -> WREQ with AWVALID=1 and WVALID=1 next cycle; no req -> stay IDLE.
REQ-010 RADDR: hold ARVALID and ARADDR stable until ARVALID&&ARREADY; then ARVALID=0, RREADY=1, -> RDATA.
REQ-011 RDATA: on RVALID&&RREADY register RDATA into rdata, pulse data_ok for exactly one cycle, RREADY=0, -> IDLE; RID and RLAST not checked.
REQ-012 WREQ: AW and W handshakes independent; each VALID drops the cycle after its own handshake, tracked by aw_done/w_done flags; both accepted (same or different cycles) -> BREADY=1, -> WRESP.
REQ-013 WRESP: on BVALID&&BREADY pulse data_ok one cycle, BREADY=0, -> IDLE; rdata unchanged on writes.
REQ-014 Latency with zero-wait slave: read req accepted cycle 0, ARVALID cycle 1, RREADY cycle 2, data_ok cycle 3; addr_ok high again in cycle 3 (back-to-back accept allowed).
REQ-015 req while busy SHALL be ignored (addr_ok=0); core holds req.
REQ-016 RVALID/BVALID asserted in any state other than RDATA/WRESP SHALL be ignored (READY low).
REQ-017 Outputs AWADDR/ARADDR/WDATA/WSTRB SHALL be stable while corresponding VALID=1.

Reset
REQ-018 On ARESETn=0 at ACLK edge: state=IDLE, AWVALID=WVALID=ARVALID=0, BREADY=RREADY=0, data_ok=0, err=0, rdata=0, captured registers=0, aw_done=w_done=0.
REQ-019 Reset mid-transaction SHALL abandon it without data_ok; addr_ok=1 first cycle after reset release.

Configuration
REQ-020 Macro SRAM_AXI_BRIDGE_RESP_ERR_EN: when defined, err pulses with data_ok when completing RRESP or BRESP != 2'b00; when undefined, err constant 0 and RRESP/BRESP ignored.

Verification
REQ-021 Read, ARREADY=1, RVALID=1 with RDATA=32'hDEADBEEF -> ARADDR=request addr in cycle 1, data_ok=1 and rdata=32'hDEADBEEF in cycle 3.
REQ-022 Write addr=32'h100, wdata=32'h12345678, wem=4'b0011; AWREADY delayed 3 cycles, WREADY=1 -> WVALID drops cycle 2, AWVALID held until cycle 4, single data_ok after BVALID.
REQ-023 ARREADY low 5 cycles -> ARVALID/ARADDR stable all 5 cycles; req during busy gives addr_ok=0.
REQ-024 Back-to-back read then write, zero-wait slave -> second accept in data_ok cycle of first; exactly two data_ok pulses.
REQ-025 Reset asserted while state=RDATA -> all VALID/READY low next cycle, no data_ok, addr_ok=1 after release.
REQ-026 With SRAM_AXI_BRIDGE_RESP_ERR_EN defined, BRESP=2'b10 -> err=1 coincident with data_ok; undefined -> err=0.
